// File: rtl/neuron_act_pkg.sv
// neuron_act_pkg: shared FSM states and CORDIC constants
// for the tanh / sigmoid activation stage (Q3.16 internal).
package neuron_act_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DIV,
    DONE
  } state_t;

  localparam int FRAC        = 16;
  localparam int OUT_FRAC    = 14;
  localparam int STEP_W      = 5;
  localparam int CORDIC_ITER = 14;
  localparam int REP_A       = 4;
  localparam int REP_B       = 13;
  localparam int ROT_STEPS   = CORDIC_ITER + 2;

  // 1/K_h = 1.207497 in Q3.16
  localparam logic [19:0] INV_KH = 20'h1351F;

  localparam int Q14_ONE  = 1 << OUT_FRAC;
  localparam int Q14_HALF = 1 << (OUT_FRAC - 1);

  // atanh(2^-i) in Q3.16, i = 1..14
  function automatic logic [19:0] atanh_q16(input logic [4:0] i);
    logic [19:0] r;
    case (i)
      5'd1:    r = 20'd35999;
      5'd2:    r = 20'd16739;
      5'd3:    r = 20'd8235;
      5'd4:    r = 20'd4101;
      5'd5:    r = 20'd2049;
      5'd6:    r = 20'd1024;
      5'd7:    r = 20'd512;
      5'd8:    r = 20'd256;
      5'd9:    r = 20'd128;
      5'd10:   r = 20'd64;
      5'd11:   r = 20'd32;
      5'd12:   r = 20'd16;
      5'd13:   r = 20'd8;
      5'd14:   r = 20'd4;
      default: r = 20'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/neuron_cordic_act_sched.sv
// cordic_step_sched: maps the rotation step counter to the
// shift index i (repeating i=4 and i=13) and its atanh angle.
module cordic_step_sched
  import neuron_act_pkg::*;
#(
  parameter int INT_W = 20
) (
  input  logic [STEP_W-1:0]       step,
  output logic [STEP_W-1:0]       shift,
  output logic signed [INT_W-1:0] angle
);

  logic [STEP_W-1:0] skip;

  // Each repeat delays every later index by one step.
  always_comb begin
    skip = '0;
    if (step >= STEP_W'(REP_A))
      skip = skip + 1'b1;
    if (step >= STEP_W'(REP_B + 1))
      skip = skip + 1'b1;
    shift = step + 1'b1 - skip;
    angle = $signed(INT_W'(atanh_q16(shift)));
  end

endmodule

// File: rtl/neuron_cordic_act.sv
// neuron_cordic_act: tanh(acc_in) via hyperbolic rotation then
// linear-vectoring divide. Ports: clk, rst, in_valid/in_ready/
// acc_in (Q3.12), out_valid/out_ready/act_out (Q1.14).
// Define NEURON_SIGMOID_EN to output sigmoid(acc_in) instead.
module neuron_cordic_act
  import neuron_act_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IN_FRAC = 12,
  parameter int ITER    = CORDIC_ITER,
  parameter int INT_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] acc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] act_out
);

  localparam int RSTEPS = ITER + (ROT_STEPS - CORDIC_ITER);
  localparam int OSH    = FRAC - OUT_FRAC;

  localparam logic signed [DATA_W-1:0] LIM =
    DATA_W'(1 << IN_FRAC);
  localparam logic signed [INT_W-1:0] RND =
    INT_W'(1 << (OSH - 1));
  localparam logic [INT_W-1:0] ONE_Q =
    INT_W'(Q14_ONE) << OSH;
`ifdef NEURON_SIGMOID_EN
  localparam logic signed [INT_W-1:0] HALF_Q =
    INT_W'(Q14_HALF) << OSH;
`endif

  state_t state, nstate;

  logic signed [INT_W-1:0] x, y, z;
  logic [STEP_W-1:0]       step;
  logic [STEP_W-1:0]       sh;
  logic signed [INT_W-1:0] ang;
  logic                    rot_last, div_last;

  cordic_step_sched #(
    .INT_W(INT_W)
  ) u_sched (
    .step (step),
    .shift(sh),
    .angle(ang)
  );

  logic signed [DATA_W-1:0] acc_h, acc_c;
  logic signed [INT_W-1:0]  z0;

`ifdef NEURON_SIGMOID_EN
  // sigmoid(a) = 0.5 + 0.5*tanh(a/2)
  assign acc_h = $signed(acc_in) >>> 1;
`else
  assign acc_h = $signed(acc_in);
`endif

  always_comb begin
    acc_c = acc_h;
    if (acc_h > LIM)
      acc_c = LIM;
    else if (acc_h < -LIM)
      acc_c = -LIM;
  end

  assign z0 = $signed({{(INT_W-DATA_W){acc_c[DATA_W-1]}},
                       acc_c}) <<< (FRAC - IN_FRAC);

  logic                    rd, dd;
  logic signed [INT_W-1:0] xr, yr, zr;
  logic signed [INT_W-1:0] yd, zd, zf, pw;
  logic [DATA_W-1:0]       qr;

  always_comb begin
    rd = !z[INT_W-1];
    xr = rd ? x + (y >>> sh) : x - (y >>> sh);
    yr = rd ? y + (x >>> sh) : y - (x >>> sh);
    zr = rd ? z - ang : z + ang;
    // x = cosh stays fixed; z accumulates y/x
    dd = !y[INT_W-1];
    pw = $signed(ONE_Q >> step);
    yd = dd ? y - (x >>> step) : y + (x >>> step);
    zd = dd ? z + pw : z - pw;
`ifdef NEURON_SIGMOID_EN
    zf = (zd >>> 1) + HALF_Q;
`else
    zf = zd;
`endif
    qr = DATA_W'((zf + RND) >>> OSH);
  end

  assign rot_last = (state == ROT) &&
                    (step == STEP_W'(RSTEPS - 1));
  assign div_last = (state == DIV) &&
                    (step == STEP_W'(ITER - 1));
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (in_valid)  nstate = ROT;
      ROT:  if (rot_last)  nstate = DIV;
      DIV:  if (div_last)  nstate = DONE;
      DONE: if (out_ready) nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      act_out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x    <= $signed(INT_W'(INV_KH));
            y    <= '0;
            z    <= z0;
            step <= '0;
          end
        end
        ROT: begin
          x <= xr;
          y <= yr;
          if (rot_last) begin
            z    <= '0;
            step <= '0;
          end else begin
            z    <= zr;
            step <= step + 1'b1;
          end
        end
        DIV: begin
          y    <= yd;
          z    <= zd;
          step <= step + 1'b1;
          if (div_last) begin
            act_out   <= qr;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_cordic_act.sv
// tb_neuron_cordic_act: real-arithmetic tanh/sigmoid model with a
// per-cycle compare process, directed and random stimulus.
module tb_neuron_cordic_act;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] acc_in = 16'h0000;
  logic [15:0] act_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] a;
    int          c;
  } tr_t;

  tr_t         q[$];
  logic [15:0] held;
  bit          prev_ov = 1'b0;

`ifdef NEURON_SIGMOID_EN
  localparam int ND = 2;
  logic [15:0] din  [ND] = '{16'h0000, 16'h1000};
  logic [15:0] dexp [ND] = '{16'h2000, 16'h2ECA};
`else
  localparam int ND = 5;
  logic [15:0] din  [ND] = '{16'h0000, 16'h0800, 16'hF800,
                             16'h7FFF, 16'h8000};
  logic [15:0] dexp [ND] = '{16'h0000, 16'h1D93, 16'hE26D,
                             16'h30BE, 16'hCF42};
`endif

  always #5 clk = ~clk;

  neuron_cordic_act dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_in   (acc_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .act_out  (act_out)
  );

  task automatic chk(input string nm, input int got,
                     input int want, input int tol);
    total++;
    if (got - want > tol || want - got > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d tol %0d",
               nm, got, want, tol);
    end
  endtask

  function automatic int model(input logic [15:0] a);
    real v, e, t;
    v = real'($signed(a)) / 4096.0;
`ifdef NEURON_SIGMOID_EN
    v = v / 2.0;
`endif
    if (v > 1.0)  v = 1.0;
    if (v < -1.0) v = -1.0;
    e = $exp(2.0 * v);
    t = (e - 1.0) / (e + 1.0);
`ifdef NEURON_SIGMOID_EN
    t = 0.5 + 0.5 * t;
`endif
    return int'($floor(t * 16384.0 + 0.5));
  endfunction

  // transaction tracker: accepts, completions, aborts
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      cyc++;
      if (out_valid && out_ready && q.size() > 0)
        void'(q.pop_front());
      if (in_valid && in_ready)
        q.push_back('{a: acc_in, c: cyc});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", int'(out_valid), 0, 0);
      chk("rst_in_ready", int'(in_ready), 0, 0);
      chk("rst_act_out", int'(act_out), 0, 0);
      prev_ov = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(q.size() == 0), 0);
      if (q.size() == 0) begin
        chk("idle_out_valid", int'(out_valid), 0, 0);
      end else if (out_valid) begin
        chk("act_out", int'($signed(act_out)), model(q[0].a), 4);
        if (!prev_ov)
          chk("latency", cyc - q[0].c, 30, 0);
        else
          chk("hold", int'(act_out), int'(held), 0);
        held = act_out;
      end else begin
        chk("busy_late", int'((cyc - q[0].c) < 30), 1, 0);
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] a, input int hold,
                      output int got);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("wait_in_ready", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    acc_in = a;
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      acc_in = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_out_valid", int'(out_valid), 1, 0);
    repeat (hold) tick();
    got = int'($signed(act_out));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int got;
    logic [15:0] a;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_in_ready", int'(in_ready), 0, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < ND; k++)
      chk("model_pin", model(din[k]), int'($signed(dexp[k])), 0);

    for (int k = 0; k < ND; k++) begin
      send(din[k], 0, got);
      chk("directed", got, int'($signed(dexp[k])), 4);
    end

    send(din[ND-1], 5, got);
    chk("hold5", got, int'($signed(dexp[ND-1])), 4);

    in_valid = 1'b1;
    acc_in = 16'h0800;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1, 0);
    repeat (35) tick();
    chk("abort_no_valid", int'(out_valid), 0, 0);
    send(16'h0800, 0, got);
    chk("after_abort", got, model(16'h0800), 4);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0)
        a = 16'($urandom);
      else
        a = 16'($urandom_range(0, 10000) - 5000);
      send(a, int'($urandom_range(0, 3)), got);
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
